// File: rtl/dnn_out_pkg.sv
// Shared constants, FSM state type and lane-select helper for the result-stream collector.
package dnn_out_pkg;

  localparam int DEF_AXI_WIDTH = 128;
  localparam int DEF_OUT_BITS  = 32;
  localparam int LANES         = DEF_AXI_WIDTH / DEF_OUT_BITS;
  localparam int LANE_W        = (LANES > 1) ? $clog2(LANES) : 1;

  typedef enum logic [1:0] {
    RECV  = 2'd0,
    DRAIN = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic [DEF_OUT_BITS-1:0] lane_word(
    input logic [DEF_AXI_WIDTH-1:0] data,
    input logic [LANE_W-1:0]        idx
  );
    return data[int'(idx) * DEF_OUT_BITS +: DEF_OUT_BITS];
  endfunction

endpackage

// File: rtl/axis_out_collector_if.sv
// AXI-Stream result channel: the engine is the master, the collector the slave.
interface axis_out_collector_if #(
  parameter int AXI_WIDTH = 128,
  parameter int W_BPT     = 8
);

  logic                   tready;
  logic                   tvalid;
  logic                   tlast;
  logic [AXI_WIDTH-1:0]   tdata;
  logic [AXI_WIDTH/8-1:0] tkeep;
  logic [W_BPT-1:0]       tuser;

  modport master (input tready, output tvalid, tlast, tdata, tkeep, tuser);
  modport slave  (output tready, input tvalid, tlast, tdata, tkeep, tuser);

endinterface

// File: rtl/out_ram.sv
// Simple dual-port result RAM: one write port, one registered read-first read port.
// The storage array is never reset; only the read register returns to zero.
module out_ram #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  // storage write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // read register: non-blocking update yields old contents on a same-cycle write
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/axis_out_collector.sv
// Collects engine output beats, unpacks kept lanes into a result RAM and tracks frame status.
// Define OUT_CHECKSUM_EN to build the running checksum of written words; otherwise it reads 0.
module axis_out_collector
  import dnn_out_pkg::*;
#(
  parameter int AXI_WIDTH      = DEF_AXI_WIDTH,
  parameter int W_BPT          = 8,
  parameter int OUT_BITS       = DEF_OUT_BITS,
  parameter int OUT_ADDR_WIDTH = 10
) (
  input  logic                      aclk,
  input  logic                      areset,
  axis_out_collector_if.slave       s_axis,
  input  logic                      clr,
  input  logic                      rd_en,
  input  logic [OUT_ADDR_WIDTH-1:0] rd_addr,
  output logic [OUT_BITS-1:0]       rd_data,
  output logic                      frame_done,
  output logic [OUT_ADDR_WIDTH:0]   word_count,
  output logic                      overflow,
  output logic [OUT_BITS-1:0]       checksum
);

  localparam int CW = OUT_ADDR_WIDTH + 1;

  state_t               state;
  state_t               state_nxt;
  logic [AXI_WIDTH-1:0] beat_data;
  logic [LANES-1:0]     beat_keep;
  logic [LANES-1:0]     keep_lanes;
  logic                 beat_last;
  logic [W_BPT-1:0]     beat_bpt;
  logic [LANE_W-1:0]    lane_idx;
  logic [CW-1:0]        ptr;
  logic                 fresh;
  logic                 handshake;
  logic                 lane_end;
  logic                 full;
  logic                 lane_kept;
  logic                 wr_en;
  logic [OUT_BITS-1:0]  lane_data;
  logic                 unused_bits;

  assign s_axis.tready = (state == RECV) & ~areset;
  assign handshake     = s_axis.tvalid & s_axis.tready;
  assign lane_end      = (lane_idx == LANE_W'(LANES - 1));
  assign full          = ptr[OUT_ADDR_WIDTH];
  assign lane_data     = lane_word(beat_data, lane_idx);
  assign lane_kept     = (state == DRAIN) & beat_keep[lane_idx] & ~clr;
  assign wr_en         = lane_kept & ~full;
  assign unused_bits   = ^{beat_bpt, s_axis.tkeep};

  // a lane's keep is taken from the keep bit of its least significant byte
  always_comb begin
    keep_lanes = '0;
    for (int i = 0; i < LANES; i++) begin
      keep_lanes[i] = s_axis.tkeep[i * (OUT_BITS / 8)];
    end
  end

  // FSM state register
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state <= RECV;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state logic; clr returns to RECV from anywhere
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = RECV;
    end else begin
      case (state)
        RECV:    state_nxt = handshake ? DRAIN : RECV;
        DRAIN:   state_nxt = lane_end ? (beat_last ? DONE : RECV) : DRAIN;
        DONE:    state_nxt = RECV;
        default: state_nxt = RECV;
      endcase
    end
  end

  // beat capture on handshake and lane walk while draining
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      beat_data <= '0;
      beat_keep <= '0;
      beat_last <= 1'b0;
      beat_bpt  <= '0;
      lane_idx  <= '0;
    end else if (handshake) begin
      beat_data <= s_axis.tdata;
      beat_keep <= keep_lanes;
      beat_last <= s_axis.tlast;
      beat_bpt  <= s_axis.tuser;
      lane_idx  <= '0;
    end else if (state == DRAIN) begin
      lane_idx <= lane_idx + LANE_W'(1);
    end
  end

  // write pointer, frame word count, overflow flag and end-of-frame pulse
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ptr        <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      fresh      <= 1'b1;
      frame_done <= 1'b0;
    end else if (clr) begin
      ptr        <= '0;
      word_count <= '0;
      overflow   <= 1'b0;
      fresh      <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= (state == DRAIN) & lane_end & beat_last;
      if (state == DONE) begin
        // count stays visible until the next frame's first write restarts it
        ptr   <= '0;
        fresh <= 1'b1;
      end else if (wr_en) begin
        ptr        <= ptr + CW'(1);
        fresh      <= 1'b0;
        word_count <= fresh ? CW'(1) : word_count + CW'(1);
      end
      if (lane_kept & full) begin
        overflow <= 1'b1;
      end
    end
  end

`ifdef OUT_CHECKSUM_EN
  // running sum of written words, restarted by the first write of each frame
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      checksum <= '0;
    end else if (clr) begin
      checksum <= '0;
    end else if (wr_en) begin
      checksum <= fresh ? lane_data : checksum + lane_data;
    end
  end
`else
  assign checksum = '0;
`endif

  out_ram #(
    .DATA_W (OUT_BITS),
    .ADDR_W (OUT_ADDR_WIDTH)
  ) u_ram (
    .clk   (aclk),
    .rst   (areset),
    .we    (wr_en),
    .waddr (ptr[OUT_ADDR_WIDTH-1:0]),
    .wdata (lane_data),
    .re    (rd_en),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

endmodule
